// File: rtl/dma_irq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// dma_irq_ctrl_pkg
// Shared definitions for the DMA interrupt controller:
//   - register offsets of the AXI4-Lite register map
//   - AXI response codes
//   - write/read channel FSM state encodings
//   - register-select decode result type
//   - byte-strobe to bit-mask helper
// ---------------------------------------------------------------------------
package dma_irq_ctrl_pkg;

  localparam logic [7:0] REG_PENDING = 8'h00;
  localparam logic [7:0] REG_ENABLE  = 8'h04;
  localparam logic [7:0] REG_RAW     = 8'h08;
  localparam logic [7:0] REG_EVCNT   = 8'h0C;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic { W_IDLE, W_RESP } wr_state_e;
  typedef enum logic { R_IDLE, R_DATA } rd_state_e;

  typedef enum logic [2:0] {
    SEL_PENDING,
    SEL_ENABLE,
    SEL_RAW,
    SEL_EVCNT,
    SEL_NONE
  } reg_sel_e;

  // Expand a 4-bit byte strobe into a 32-bit per-bit write mask.
  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] mask;
    mask = 32'h0000_0000;
    for (int b = 0; b < 4; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dma_irq_edge_detect.sv
// ---------------------------------------------------------------------------
// dma_irq_edge_detect
// Per-source rising-edge detector for the DMA done lines.
// Optional build macro: IRQ_CTRL_SYNC_EN -- when defined, each source first
// passes through a 2-flop synchronizer (reset 0); otherwise irq_i is used as is.
// Ports:
//   clock   in   single clock
//   reset   in   asynchronous active-high reset
//   irq_i   in   [IrqCount] raw interrupt sources
//   raw_o   out  [IrqCount] source level after optional synchronization
//   rise_o  out  [IrqCount] one-cycle pulse on each 0->1 transition of raw_o
// ---------------------------------------------------------------------------
module dma_irq_edge_detect
  import dma_irq_ctrl_pkg::*;
#(
  parameter int IrqCount = 2
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IrqCount-1:0] irq_i,
  output logic [IrqCount-1:0] raw_o,
  output logic [IrqCount-1:0] rise_o
);

  logic [IrqCount-1:0] prev_q;

`ifdef IRQ_CTRL_SYNC_EN
  logic [IrqCount-1:0] sync1_q;
  logic [IrqCount-1:0] sync2_q;

  // Two-stage synchronizer for the asynchronous DMA done lines
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_i;
      sync2_q <= sync1_q;
    end
  end

  assign raw_o = sync2_q;
`else
  assign raw_o = irq_i;
`endif

  // Previous-level register used to detect 0->1 transitions
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
    end else begin
      prev_q <= raw_o;
    end
  end

  assign rise_o = raw_o & ~prev_q;

endmodule

// File: rtl/dma_irq_controller.sv
// ---------------------------------------------------------------------------
// dma_irq_controller
// AXI4-Lite interrupt controller for the FastVDMA done outputs. Each source is
// edge detected, latched into PENDING, masked by ENABLE and driven out as a
// registered level interrupt (irq_o = pending & enable).
// Register map (word aligned, addr[1:0] ignored):
//   0x0 PENDING RW1C   0x4 ENABLE RW   0x8 RAW RO   0xC EVCNT RO (write clears)
// Optional build macro: IRQ_CTRL_SYNC_EN (2-flop input synchronizer, see
// dma_irq_edge_detect).
// Ports:
//   clock, reset                 clock / asynchronous active-high reset
//   irq_i  [IrqCount]            sources (bit0 = writerDone, bit1 = readerDone)
//   irq_o  [IrqCount]            registered level interrupts
//   aw*/w*/b*                    AXI4-Lite write address/data/response channels
//   ar*/r*                       AXI4-Lite read address/data channels
// ---------------------------------------------------------------------------
module dma_irq_controller
  import dma_irq_ctrl_pkg::*;
#(
  parameter int IrqCount  = 2,
  parameter int AddrWidth = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [IrqCount-1:0]  irq_i,
  output logic [IrqCount-1:0]  irq_o,
  input  logic [AddrWidth-1:0] awaddr,
  input  logic                 awvalid,
  output logic                 awready,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 wvalid,
  output logic                 wready,
  output logic [1:0]           bresp,
  output logic                 bvalid,
  input  logic                 bready,
  input  logic [AddrWidth-1:0] araddr,
  input  logic                 arvalid,
  output logic                 arready,
  output logic [31:0]          rdata,
  output logic [1:0]           rresp,
  output logic                 rvalid,
  input  logic                 rready
);

  // Map an address onto a register; anything outside 0x0-0xC is unmapped.
  function automatic reg_sel_e decode_addr(input logic [AddrWidth-1:0] addr);
    logic [31:0] off;
    reg_sel_e    sel;
    off = 32'(addr) & 32'hFFFF_FFFC;
    case (off)
      32'(REG_PENDING): sel = SEL_PENDING;
      32'(REG_ENABLE):  sel = SEL_ENABLE;
      32'(REG_RAW):     sel = SEL_RAW;
      32'(REG_EVCNT):   sel = SEL_EVCNT;
      default:          sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  logic [IrqCount-1:0]  raw_s, rise_s;
  logic [IrqCount-1:0]  pending_q, pending_d, enable_q, enable_d, irq_q;
  logic [15:0]          evcnt_q, evcnt_d;
  logic                 evcnt_clr_s;
  logic [5:0]           rise_cnt_s;
  logic [16:0]          evcnt_sum_s;

  wr_state_e            wr_state_q;
  rd_state_e            rd_state_q;
  logic                 aw_held_q, w_held_q;
  logic [AddrWidth-1:0] awaddr_q;
  logic [31:0]          wdata_q;
  logic [3:0]           wstrb_q;
  logic                 awready_q, wready_q, bvalid_q;
  logic [1:0]           bresp_q;
  logic                 arready_q, rvalid_q;
  logic [31:0]          rdata_q;
  logic [1:0]           rresp_q;

  logic                 aw_hs_s, w_hs_s, aw_have_s, w_have_s, wr_commit_s;
  logic [AddrWidth-1:0] wr_addr_s;
  logic [31:0]          wr_data_s, wr_mask_s;
  logic [3:0]           wr_strb_s;
  logic [IrqCount-1:0]  wr_bits_s, wr_bmask_s;
  reg_sel_e             wr_sel_s, rd_sel_s;
  logic [1:0]           wr_resp_s, rd_resp_s;
  logic [31:0]          rd_data_s;
  logic                 unused_s;

  dma_irq_edge_detect #(
    .IrqCount(IrqCount)
  ) u_edge (
    .clock (clock),
    .reset (reset),
    .irq_i (irq_i),
    .raw_o (raw_s),
    .rise_o(rise_s)
  );

  // A beat counts as "held" if latched earlier or handshaking this cycle, so
  // AW and W may arrive in either order or together.
  assign aw_hs_s     = awvalid & awready_q;
  assign w_hs_s      = wvalid & wready_q;
  assign aw_have_s   = aw_held_q | aw_hs_s;
  assign w_have_s    = w_held_q | w_hs_s;
  assign wr_commit_s = (wr_state_q == W_IDLE) & aw_have_s & w_have_s;

  assign wr_addr_s   = aw_held_q ? awaddr_q : awaddr;
  assign wr_data_s   = w_held_q ? wdata_q : wdata;
  assign wr_strb_s   = w_held_q ? wstrb_q : wstrb;
  assign wr_mask_s   = strb_to_mask(wr_strb_s);
  assign wr_bits_s   = wr_data_s[IrqCount-1:0];
  assign wr_bmask_s  = wr_mask_s[IrqCount-1:0];
  assign wr_sel_s    = decode_addr(wr_addr_s);
  assign rd_sel_s    = decode_addr(araddr);

  // Data bits above IrqCount are intentionally discarded.
  assign unused_s    = ^{wr_data_s, wr_mask_s};

  // Next-state of PENDING/ENABLE/EVCNT and the write response code
  always_comb begin
    pending_d   = pending_q;
    enable_d    = enable_q;
    evcnt_clr_s = 1'b0;
    wr_resp_s   = RESP_SLVERR;
    if (wr_commit_s) begin
      case (wr_sel_s)
        SEL_PENDING: begin
          pending_d = pending_q & ~(wr_bits_s & wr_bmask_s);
          wr_resp_s = RESP_OKAY;
        end
        SEL_ENABLE: begin
          enable_d  = (enable_q & ~wr_bmask_s) | (wr_bits_s & wr_bmask_s);
          wr_resp_s = RESP_OKAY;
        end
        SEL_EVCNT: begin
          evcnt_clr_s = 1'b1;
          wr_resp_s   = RESP_OKAY;
        end
        default: begin
          wr_resp_s = RESP_SLVERR;
        end
      endcase
    end else begin
      wr_resp_s = RESP_SLVERR;
    end
    // A new edge wins over a simultaneous W1C of the same bit.
    pending_d = pending_d | rise_s;
  end

  // Saturating edge counter; a clear coinciding with edges keeps those edges
  always_comb begin
    rise_cnt_s = 6'd0;
    for (int i = 0; i < IrqCount; i++) begin
      rise_cnt_s = rise_cnt_s + 6'(rise_s[i]);
    end
    evcnt_sum_s = (evcnt_clr_s ? 17'd0 : {1'b0, evcnt_q}) + 17'(rise_cnt_s);
    if (evcnt_sum_s[16]) begin
      evcnt_d = 16'hFFFF;
    end else begin
      evcnt_d = evcnt_sum_s[15:0];
    end
  end

  // Read data / response for the address currently presented on AR
  always_comb begin
    rd_data_s = 32'h0000_0000;
    rd_resp_s = RESP_OKAY;
    case (rd_sel_s)
      SEL_PENDING: rd_data_s = 32'(pending_q);
      SEL_ENABLE:  rd_data_s = 32'(enable_q);
      SEL_RAW:     rd_data_s = 32'(raw_s);
      SEL_EVCNT:   rd_data_s = {16'h0000, evcnt_q};
      default: begin
        rd_data_s = 32'h0000_0000;
        rd_resp_s = RESP_SLVERR;
      end
    endcase
  end

  // Interrupt state registers and registered interrupt outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      enable_q  <= '0;
      evcnt_q   <= 16'h0000;
      irq_q     <= '0;
    end else begin
      pending_q <= pending_d;
      enable_q  <= enable_d;
      evcnt_q   <= evcnt_d;
      irq_q     <= pending_q & enable_q;
    end
  end

  // Write channel FSM: latch AW/W independently, commit once, hold B until taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_state_q <= W_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= 32'h0000_0000;
      wstrb_q    <= 4'h0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (wr_commit_s) begin
            wr_state_q <= W_RESP;
            bvalid_q   <= 1'b1;
            bresp_q    <= wr_resp_s;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
          end else begin
            if (aw_hs_s) begin
              aw_held_q <= 1'b1;
              awaddr_q  <= awaddr;
            end
            if (w_hs_s) begin
              w_held_q <= 1'b1;
              wdata_q  <= wdata;
              wstrb_q  <= wstrb;
            end
            // Stop accepting a channel once its beat is latched.
            awready_q <= ~aw_have_s;
            wready_q  <= ~w_have_s;
          end
        end
        W_RESP: begin
          if (bready) begin
            wr_state_q <= W_IDLE;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        default: begin
          wr_state_q <= W_IDLE;
          bvalid_q   <= 1'b0;
          awready_q  <= 1'b0;
          wready_q   <= 1'b0;
        end
      endcase
    end
  end

  // Read channel FSM: capture data on AR handshake, hold R until taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0000_0000;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (arvalid && arready_q) begin
            rd_state_q <= R_DATA;
            rdata_q    <= rd_data_s;
            rresp_q    <= rd_resp_s;
            rvalid_q   <= 1'b1;
            arready_q  <= 1'b0;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            rd_state_q <= R_IDLE;
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
          end
        end
        default: begin
          rd_state_q <= R_IDLE;
          rvalid_q   <= 1'b0;
          arready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq_o   = irq_q;
  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_dma_irq_controller.sv
// ---------------------------------------------------------------------------
// tb_dma_irq_controller
// Directed self-checking bench for dma_irq_controller (IrqCount=4, AddrWidth=5
// so that 0x10/0x14 are unmapped addresses). Inputs are driven and outputs
// sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_dma_irq_controller;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int LIMIT = 20;

  logic          clock;
  logic          reset;
  logic [N-1:0]  irq_i;
  logic [N-1:0]  irq_o;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [31:0]   wdata;
  logic [3:0]    wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;

  int n_checks;
  int n_fail;

  dma_irq_controller #(
    .IrqCount (N),
    .AddrWidth(AW)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .irq_i  (irq_i),
    .irq_o  (irq_o),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Full AXI-Lite write with AW and W presented together; returns bresp.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    int   n;
    logic aw_hs, w_hs;
    awaddr = a; awvalid = 1'b1;
    wdata  = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < LIMIT) begin
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      @(negedge clock);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      n++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_accept_bound", 32'(n < LIMIT), 32'd1);
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    check("wr_bvalid_bound", 32'(n < LIMIT), 32'd1);
    resp = bresp;
    @(negedge clock);
    bready = 1'b0;
  endtask

  // Full AXI-Lite read; returns rdata and rresp.
  task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < LIMIT) begin
      @(negedge clock);
      n++;
    end
    check("rd_bound", 32'(n < LIMIT), 32'd1);
    d = rdata; resp = rresp;
    rready = 1'b1;
    @(negedge clock);
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; irq_i = '0;
    awaddr = '0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_irq_o", 32'(irq_o), 32'h0);
    check("rst_ctrl", {25'h0, awready, wready, bvalid, arready, rvalid, bresp[1], rresp[1]}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    @(negedge clock);

    // Single pulse on source 1 with both enabled
    axi_write(5'h04, 32'h3, 4'hF, r);
    check("en_wr_resp", 32'(r), 32'h0);
    irq_i = 4'b0010;
    @(negedge clock);
    irq_i = 4'b0000;
    check("irq_lat1", 32'(irq_o), 32'h0);
    @(negedge clock);
    check("irq_lat2", 32'(irq_o), 32'h2);
    axi_read(5'h00, d, r);
    check("pend_after_pulse", d, 32'h2);
    axi_read(5'h0C, d, r);
    check("evcnt_one", d, 32'h1);

    // W1C with partial enable; two simultaneous edges count as two
    irq_i = 4'b0011;
    @(negedge clock);
    irq_i = 4'b0000;
    @(negedge clock);
    axi_write(5'h04, 32'h1, 4'hF, r);
    @(negedge clock);
    check("irq_en1", 32'(irq_o), 32'h1);
    axi_write(5'h00, 32'h1, 4'hF, r);
    check("w1c_resp", 32'(r), 32'h0);
    axi_read(5'h00, d, r);
    check("w1c_pend", d, 32'h2);
    check("w1c_irq_o", 32'(irq_o), 32'h0);
    axi_read(5'h0C, d, r);
    check("evcnt_three", d, 32'h3);

    // W three cycles ahead of AW, B back-pressured for five cycles
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clock);
    wvalid = 1'b0;
    check("w_latched_ready", 32'(wready), 32'h0);
    check("aw_still_ready", 32'(awready), 32'h1);
    @(negedge clock);
    @(negedge clock);
    awaddr = 5'h04; awvalid = 1'b1;
    @(negedge clock);
    awvalid = 1'b0;
    check("bvalid_set", 32'(bvalid), 32'h1);
    awaddr = 5'h04; awvalid = 1'b1; wdata = 32'hA; wvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bvalid_hold", 32'(bvalid), 32'h1);
      check("no_second_accept", {30'h0, awready, wready}, 32'h0);
      @(negedge clock);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("split_bresp", 32'(bresp), 32'h0);
    bready = 1'b1;
    @(negedge clock);
    bready = 1'b0;
    check("bvalid_clear", 32'(bvalid), 32'h0);
    axi_read(5'h04, d, r);
    check("split_enable", d, 32'h5);

    // W1C of bit0 coinciding with a bit0 rise: set wins
    irq_i = 4'b0001;
    axi_write(5'h00, 32'h1, 4'hF, r);
    irq_i = 4'b0000;
    axi_read(5'h00, d, r);
    check("set_beats_clear", d, 32'h3);

    // EVCNT clear coinciding with an edge
    irq_i = 4'b0010;
    axi_write(5'h0C, 32'h0, 4'hF, r);
    irq_i = 4'b0000;
    check("evcnt_clr_resp", 32'(r), 32'h0);
    axi_read(5'h0C, d, r);
    check("evcnt_clr_edge", d, 32'h1);

    // Strobes and bits above IrqCount
    axi_write(5'h04, 32'hFFFF_FFFF, 4'hF, r);
    axi_read(5'h04, d, r);
    check("en_upper_bits", d, 32'hF);
    axi_write(5'h04, 32'h0, 4'h0, r);
    axi_read(5'h04, d, r);
    check("en_strb_none", d, 32'hF);
    axi_write(5'h04, 32'h0, 4'b1110, r);
    axi_read(5'h04, d, r);
    check("en_strb_upper", d, 32'hF);
    axi_write(5'h04, 32'h6, 4'b0001, r);
    axi_read(5'h04, d, r);
    check("en_strb_low", d, 32'h6);

    // RAW reflects current inputs
    irq_i = 4'b1010;
    @(negedge clock);
    axi_read(5'h08, d, r);
    check("raw_val", d, 32'hA);
    check("raw_resp", 32'(r), 32'h0);
    irq_i = 4'b0000;

    // Unmapped / read-only accesses
    axi_read(5'h10, d, r);
    check("unmap_rd_resp", 32'(r), 32'h2);
    check("unmap_rd_data", d, 32'h0);
    axi_write(5'h08, 32'hF, 4'hF, r);
    check("raw_wr_resp", 32'(r), 32'h2);
    axi_write(5'h10, 32'hFFFF_FFFF, 4'hF, r);
    check("unmap_wr10_resp", 32'(r), 32'h2);
    axi_write(5'h14, 32'h0, 4'hF, r);
    check("unmap_wr14_resp", 32'(r), 32'h2);
    axi_read(5'h00, d, r);
    check("unmap_pend_kept", d, 32'hB);
    axi_read(5'h04, d, r);
    check("unmap_en_kept", d, 32'h6);

    // Saturation: 17500 x 4 = 70000 edges
    for (int i = 0; i < 17500; i++) begin
      irq_i = 4'hF;
      @(negedge clock);
      irq_i = 4'h0;
      @(negedge clock);
    end
    axi_read(5'h0C, d, r);
    check("evcnt_sat", d, 32'hFFFF);

    // Reset during R_DATA aborts the read
    araddr = 5'h04; arvalid = 1'b1;
    for (int i = 0; i < LIMIT && !arready; i++) @(negedge clock);
    @(negedge clock);
    arvalid = 1'b0;
    check("rdata_pending", 32'(rvalid), 32'h1);
    check("irq_before_rst", 32'(irq_o), 32'h6);
    reset = 1'b1;
    @(negedge clock);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_irq_mid", 32'(irq_o), 32'h0);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("no_resp_after_rst", 32'(rvalid), 32'h0);
    axi_read(5'h00, d, r);
    check("rst_pend", d, 32'h0);
    axi_read(5'h04, d, r);
    check("rst_en", d, 32'h0);
    axi_read(5'h0C, d, r);
    check("rst_evcnt", d, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
